rggen_bus_arbiter: RTL and testbench

- Shares one downstream rggen register-bus port among HOSTS upstream requesters, for example an AXI4-Lite adapter and a debug/APB host feeding one register-block decoder.
- Round-robin arbitration with a registered grant.
- The grant is locked from issue until the downstream `ready`.
- Response signals are routed back to the granted host only.

---
 rtl/rggen_rtl_pkg.sv | 22 ++
 rtl/rggen_bus_arbiter_rr_select.sv | 37 +++
 rtl/rggen_bus_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_rggen_bus_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_rtl_pkg.sv
// -----------------------------------------------------------------------------
// rggen_rtl_pkg
//   Shared rggen register-bus types used by bus adapters and arbiters.
//   - rggen_access : 2-bit access kind carried with each request
//   - rggen_status : 2-bit completion status returned with each response
// -----------------------------------------------------------------------------
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_POSTED_WRITE = 2'b01,
    RGGEN_READ         = 2'b10,
    RGGEN_WRITE        = 2'b11
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY        = 2'b00,
    RGGEN_EXOKAY      = 2'b01,
    RGGEN_SLAVE_ERROR = 2'b10,
    RGGEN_ERROR       = 2'b11
  } rggen_status;

endpackage

// File: rtl/rggen_bus_arbiter_rr_select.sv
// -----------------------------------------------------------------------------
// rggen_bus_arbiter_rr_select
//   Purely combinational round-robin winner search, reusable by any rggen
//   block that shares one resource among N requesters.
//   Ports:
//     i_request : N-bit request vector
//     i_pointer : index of the highest-priority requester (must be < N)
//     o_grant   : one-hot winner, or zero when nothing is requested
// -----------------------------------------------------------------------------
module rggen_bus_arbiter_rr_select #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_request,
  input  logic [PW-1:0] i_pointer,
  output logic [N-1:0]  o_grant
);

  // Two copies of the request vector turn the modulo wrap into a linear
  // search: the first set bit at or above the pointer is the winner.
  logic [2*N-1:0] request_x2;

  assign request_x2 = {i_request, i_request};

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would infer a latch.
    o_grant = '0;
    // Scanning downward lets the lowest qualifying index overwrite the rest.
    for (int i = 2*N-1; i >= 0; i--) begin
      if (request_x2[i] && (i >= int'(i_pointer))) begin
        o_grant = N'(1) << (i % N);
      end
    end
  end

endmodule

// File: rtl/rggen_bus_arbiter.sv
// -----------------------------------------------------------------------------
// rggen_bus_arbiter
//   Shares one downstream rggen register-bus port among HOSTS requesters with
//   round-robin arbitration. The grant is registered in an IDLE cycle and held
//   until the downstream completes; the response is routed to the granted
//   host only.
//
//   Build option:
//     RGGEN_BUS_ARBITER_TIMEOUT_EN - when defined, a BUSY transfer that sees no
//       i_ready for TIMEOUT_CYCLES cycles is completed with RGGEN_SLAVE_ERROR.
//
//   Ports:
//     i_clk, i_rst_n       clock, asynchronous active-low reset
//     i_host_*             per-host request (valid, access, address, data, strobe)
//     o_host_ready         per-host completion pulse (one-hot or zero)
//     o_host_status/_read_data  shared response, zero outside completion
//     o_valid..o_strobe    downstream request
//     i_ready/_status/_read_data  downstream response
//     o_grant, o_busy      registered grant and transfer-in-flight flag
// -----------------------------------------------------------------------------
module rggen_bus_arbiter
  import rggen_rtl_pkg::*;
#(
  parameter int HOSTS          = 2,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [HOSTS-1:0]                  i_host_valid,
  input  logic [HOSTS*2-1:0]                i_host_access,
  input  logic [HOSTS*ADDRESS_WIDTH-1:0]    i_host_address,
  input  logic [HOSTS*BUS_WIDTH-1:0]        i_host_write_data,
  input  logic [HOSTS*(BUS_WIDTH/8)-1:0]    i_host_strobe,
  output logic [HOSTS-1:0]                  o_host_ready,
  output logic [1:0]                        o_host_status,
  output logic [BUS_WIDTH-1:0]              o_host_read_data,
  output logic                              o_valid,
  output logic [1:0]                        o_access,
  output logic [ADDRESS_WIDTH-1:0]          o_address,
  output logic [BUS_WIDTH-1:0]              o_write_data,
  output logic [BUS_WIDTH/8-1:0]            o_strobe,
  input  logic                              i_ready,
  input  logic [1:0]                        i_status,
  input  logic [BUS_WIDTH-1:0]              i_read_data,
  output logic [HOSTS-1:0]                  o_grant,
  output logic                              o_busy
);

  localparam int STROBE_WIDTH  = BUS_WIDTH / 8;
  localparam int POINTER_WIDTH = (HOSTS > 1) ? $clog2(HOSTS) : 1;

  if ((HOSTS < 1) || (HOSTS > 16) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("rggen_bus_arbiter: HOSTS must be 1..16 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [HOSTS-1:0]         grant_q, grant_d;
  logic [POINTER_WIDTH-1:0] pointer_q, pointer_d;
  logic [POINTER_WIDTH-1:0] pointer_next;
  logic [HOSTS-1:0]         select;
  logic                     busy;
  logic                     timeout;
  logic                     complete;

  rggen_bus_arbiter_rr_select #(
    .N  (HOSTS),
    .PW (POINTER_WIDTH)
  ) u_rr_select (
    .i_request (i_host_valid),
    .i_pointer (pointer_q),
    .o_grant   (select)
  );

  assign busy     = (state_q == BUSY);
  assign complete = busy && (i_ready || timeout);
  assign o_valid  = busy;
  assign o_busy   = busy;
  assign o_grant  = grant_q;

  // The grant is one-hot or zero, so an AND-OR mux suffices and the
  // downstream fields read as zero whenever nothing is granted.
  always_comb begin
    o_access     = '0;
    o_address    = '0;
    o_write_data = '0;
    o_strobe     = '0;
    pointer_next = '0;
    for (int h = 0; h < HOSTS; h++) begin
      if (grant_q[h]) begin
        o_access     |= i_host_access[2*h +: 2];
        o_address    |= i_host_address[ADDRESS_WIDTH*h +: ADDRESS_WIDTH];
        o_write_data |= i_host_write_data[BUS_WIDTH*h +: BUS_WIDTH];
        o_strobe     |= i_host_strobe[STROBE_WIDTH*h +: STROBE_WIDTH];
        pointer_next  = (h == HOSTS-1) ? '0 : POINTER_WIDTH'(h + 1);
      end
    end
  end

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
  localparam int COUNTER_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;

  logic [COUNTER_WIDTH-1:0] counter_q, counter_d;

  assign timeout = busy && !i_ready
                && (counter_q == COUNTER_WIDTH'(TIMEOUT_CYCLES - 1));

  // Held at zero while IDLE, so every BUSY period starts counting from zero.
  always_comb begin
    counter_d = '0;
    if (busy && !i_ready) begin
      counter_d = counter_q + COUNTER_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      counter_q <= '0;
    end else begin
      counter_q <= counter_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Response pass-through: i_ready has priority over a coinciding timeout.
  always_comb begin
    o_host_ready     = complete ? grant_q : '0;
    o_host_status    = '0;
    o_host_read_data = '0;
    if (busy && i_ready) begin
      o_host_status    = i_status;
      o_host_read_data = i_read_data;
    end else if (timeout) begin
      o_host_status    = RGGEN_SLAVE_ERROR;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    pointer_d = pointer_q;
    case (state_q)
      IDLE: begin
        if (|i_host_valid) begin
          grant_d = select;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (complete) begin
          grant_d   = '0;
          pointer_d = pointer_next;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!i_rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      pointer_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      pointer_q <= pointer_d;
    end
  end

  // Hosts must hold valid and request fields until their own ready.
  for (genvar h = 0; h < HOSTS; h++) begin : g_protocol
    assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (i_host_valid[h] && !o_host_ready[h]) |=>
        (i_host_valid[h]
         && $stable(i_host_access[2*h +: 2])
         && $stable(i_host_address[ADDRESS_WIDTH*h +: ADDRESS_WIDTH])))
      else $error("rggen_bus_arbiter: host %0d dropped or changed its request before ready", h);
  end

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
module tb_rggen_bus_arbiter;

  localparam int H  = 4;
  localparam int AW = 8;
  localparam int BW = 32;
  localparam int SW = BW / 8;
  localparam int TO = 8;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic [H-1:0]    i_host_valid;
  logic [H*2-1:0]  i_host_access;
  logic [H*AW-1:0] i_host_address;
  logic [H*BW-1:0] i_host_write_data;
  logic [H*SW-1:0] i_host_strobe;
  logic [H-1:0]    o_host_ready;
  logic [1:0]      o_host_status;
  logic [BW-1:0]   o_host_read_data;
  logic            o_valid;
  logic [1:0]      o_access;
  logic [AW-1:0]   o_address;
  logic [BW-1:0]   o_write_data;
  logic [SW-1:0]   o_strobe;
  logic            i_ready;
  logic [1:0]      i_status;
  logic [BW-1:0]   i_read_data;
  logic [H-1:0]    o_grant;
  logic            o_busy;

  rggen_bus_arbiter #(
    .HOSTS          (H),
    .ADDRESS_WIDTH  (AW),
    .BUS_WIDTH      (BW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_host_valid      (i_host_valid),
    .i_host_access     (i_host_access),
    .i_host_address    (i_host_address),
    .i_host_write_data (i_host_write_data),
    .i_host_strobe     (i_host_strobe),
    .o_host_ready      (o_host_ready),
    .o_host_status     (o_host_status),
    .o_host_read_data  (o_host_read_data),
    .o_valid           (o_valid),
    .o_access          (o_access),
    .o_address         (o_address),
    .o_write_data      (o_write_data),
    .o_strobe          (o_strobe),
    .i_ready           (i_ready),
    .i_status          (i_status),
    .i_read_data       (i_read_data),
    .o_grant           (o_grant),
    .o_busy            (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]    access;
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
    logic [SW-1:0] strb;
  } req_t;

  typedef struct {
    int   host;
    req_t req;
    int   cyc;
  } grant_exp_t;

  typedef struct {
    int            host;
    logic [1:0]    status;
    logic [BW-1:0] rdata;
    int            cyc;
  } resp_exp_t;

  grant_exp_t grant_q[$];
  resp_exp_t  resp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // Hosts hold a pending request until served; the shared bus serves one
  // transfer at a time, taking the first pending host in circular order
  // starting just after the previously served host.
  req_t          host_req[H];
  bit            pending[H];
  bit            just_done[H];
  bit            cont_mask[H];
  int            m_owner = -1;
  int            m_ptr = 0;
  int            m_wait = 0;
  int            m_busy = 0;
  int            req_pct = 0;
  int            fixed_lat = -1;
  int            fixed_status = -1;
  bit            never_ready = 0;
  bit            fix_rdata_en = 0;
  logic [BW-1:0] fix_rdata = '0;

  function automatic req_t rand_req();
    req_t r;
    r.access = 2'($urandom_range(1, 3));
    r.addr   = AW'($urandom);
    r.data   = $urandom;
    r.strb   = SW'($urandom);
    return r;
  endfunction

  function automatic req_t mk_req(logic [1:0] a, logic [AW-1:0] ad, logic [BW-1:0] d, logic [SW-1:0] s);
    req_t r;
    r.access = a; r.addr = ad; r.data = d; r.strb = s;
    return r;
  endfunction

  task automatic drive_hosts();
    for (int h = 0; h < H; h++) begin
      i_host_valid[h]              = pending[h];
      i_host_access[2*h +: 2]      = host_req[h].access;
      i_host_address[AW*h +: AW]   = host_req[h].addr;
      i_host_write_data[BW*h +: BW] = host_req[h].data;
      i_host_strobe[SW*h +: SW]    = host_req[h].strb;
    end
  endtask

  task automatic post(int h, req_t r);
    host_req[h] = r;
    pending[h]  = 1'b1;
  endtask

  task automatic retire();
    just_done[m_owner] = 1'b1;
    m_ptr   = (m_owner + 1) % H;
    m_owner = -1;
  endtask

  task automatic step_begin();
    @(posedge i_clk);
    #1;
    for (int h = 0; h < H; h++) begin
      if (just_done[h]) begin
        just_done[h] = 1'b0;
        pending[h]   = 1'b0;
        if (cont_mask[h]) post(h, rand_req());
      end
    end
  endtask

  task automatic step_end();
    for (int h = 0; h < H; h++) begin
      if (!pending[h] && (req_pct > 0) && ($urandom_range(0, 99) < req_pct)) post(h, rand_req());
    end
    drive_hosts();
    i_ready     = 1'b0;
    i_status    = 2'($urandom);
    i_read_data = $urandom;
    if (m_owner < 0) begin
      for (int k = 0; k < H; k++) begin
        int h;
        h = (m_ptr + k) % H;
        if (pending[h]) begin
          grant_q.push_back('{h, host_req[h], cyc + 1});
          m_owner = h;
          m_wait  = (fixed_lat < 0) ? $urandom_range(0, 3) : fixed_lat;
          m_busy  = 0;
          break;
        end
      end
    end else begin
      m_busy++;
      if (!never_ready && (m_wait == 0)) begin
        resp_exp_t r;
        r.host   = m_owner;
        r.status = (fixed_status < 0) ? 2'($urandom) : 2'(fixed_status);
        r.rdata  = fix_rdata_en ? fix_rdata : $urandom;
        r.cyc    = cyc;
        i_ready     = 1'b1;
        i_status    = r.status;
        i_read_data = r.rdata;
        resp_q.push_back(r);
        retire();
      end else begin
        if (m_wait > 0) m_wait--;
`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
        if (m_busy == TO) begin
          resp_q.push_back('{m_owner, 2'b10, '0, cyc});
          retire();
        end
`endif
      end
    end
  endtask

  task automatic run(int n);
    repeat (n) begin
      step_begin();
      step_end();
    end
  endtask

  task automatic quiesce();
    req_pct = 0;
    for (int h = 0; h < H; h++) cont_mask[h] = 1'b0;
    run(40);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    grant_exp_t cur;
    resp_exp_t  r;
    bit         in_txn;
    in_txn = 1'b0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        in_txn = 1'b0;
      end else begin
        check("busy_vs_valid", o_busy, o_valid);
        if (o_valid) begin
          if (!in_txn) begin
            check("grant_expected", grant_q.size() != 0, 1);
            if (grant_q.size() != 0) begin
              cur    = grant_q.pop_front();
              in_txn = 1'b1;
              check("grant_cycle", cur.cyc, cyc);
            end
          end
          if (in_txn) begin
            check("o_grant",      o_grant,      H'(1) << cur.host);
            check("o_access",     o_access,     cur.req.access);
            check("o_address",    o_address,    cur.req.addr);
            check("o_write_data", o_write_data, cur.req.data);
            check("o_strobe",     o_strobe,     cur.req.strb);
          end
        end else begin
          check("o_grant_idle", o_grant, 0);
        end
        if (|o_host_ready) begin
          check("resp_expected", resp_q.size() != 0, 1);
          if (resp_q.size() != 0) begin
            r = resp_q.pop_front();
            check("host_ready",  o_host_ready,     H'(1) << r.host);
            check("host_status", o_host_status,    r.status);
            check("host_rdata",  o_host_read_data, r.rdata);
            check("resp_cycle",  r.cyc,            cyc);
          end
          in_txn = 1'b0;
        end else begin
          check("status_idle", o_host_status,    0);
          check("rdata_idle",  o_host_read_data, 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int h = 0; h < H; h++) begin
      pending[h] = 1'b0; just_done[h] = 1'b0; cont_mask[h] = 1'b0;
      host_req[h] = mk_req(2'b10, '0, '0, '0);
    end
    drive_hosts();
    i_rst_n     = 1'b0;
    i_ready     = 1'b1;
    i_status    = 2'b11;
    i_read_data = 32'hFFFF_FFFF;
    #12;
    check("rst_o_valid",      o_valid,          0);
    check("rst_o_grant",      o_grant,          0);
    check("rst_o_busy",       o_busy,           0);
    check("rst_host_ready",   o_host_ready,     0);
    check("rst_host_status",  o_host_status,    0);
    check("rst_host_rdata",   o_host_read_data, 0);
    check("rst_o_address",    o_address,        0);
    i_ready = 1'b0;
    @(posedge i_clk);
    #3;
    i_rst_n = 1'b1;

    // Single host-0 write, downstream ready two cycles after o_valid.
    fixed_lat = 2; fixed_status = 0;
    step_begin(); post(0, mk_req(2'b11, 8'h10, 32'hDEAD_BEEF, 4'hF)); step_end();
    run(6);
    check("busy_back_to_idle", o_busy, 0);
    fixed_status = -1;

    // Hosts 0 and 1 continuously requesting, immediate ready.
    fixed_lat = 0; cont_mask[0] = 1'b1; cont_mask[1] = 1'b1;
    step_begin(); post(0, rand_req()); post(1, rand_req()); step_end();
    run(8);
    quiesce();

    // Host 1 read arrives while host 0 waits five cycles for ready.
    fixed_lat = 5; fix_rdata_en = 1'b1; fix_rdata = 32'h1234_5678;
    step_begin(); post(0, rand_req()); step_end();
    run(1);
    step_begin(); post(1, mk_req(2'b10, 8'h44, 32'h0, 4'h0)); step_end();
    run(16);
    fix_rdata_en = 1'b0;

    // Pointer left at 3 by host 2; hosts 0 and 2 then request together.
    fixed_lat = 0;
    step_begin(); post(2, rand_req()); step_end();
    run(1);
    step_begin(); post(0, rand_req()); post(2, rand_req()); step_end();
    run(6);

    // Reset in the middle of a long BUSY period.
    fixed_lat = 20;
    step_begin(); post(0, rand_req()); step_end();
    run(2);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("midrst_o_valid", o_valid, 0);
    check("midrst_o_grant", o_grant, 0);
    check("midrst_o_busy",  o_busy,  0);
    m_owner = -1; m_ptr = 0;
    for (int h = 0; h < H; h++) begin pending[h] = 1'b0; just_done[h] = 1'b0; end
    grant_q.delete(); resp_q.delete();
    drive_hosts();
    i_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    #3;
    i_rst_n = 1'b1;
    fixed_lat = 0;
    step_begin(); post(3, rand_req()); post(1, rand_req()); step_end();
    run(6);

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
    // Downstream never answers: the arbiter must give up in the 8th BUSY cycle.
    never_ready = 1'b1; fixed_lat = -1;
    step_begin(); post(1, rand_req()); step_end();
    run(12);
    never_ready = 1'b0;
`endif

    // Randomized traffic from all hosts with random downstream latency.
    fixed_lat = -1; req_pct = 35;
    run(400);
    quiesce();

    check("grant_queue_drained", grant_q.size(), 0);
    check("resp_queue_drained",  resp_q.size(),  0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
